// File: rtl/verifier_compute_beta_pkg.sv
// Field definition and modular helpers shared by the beta(w,z) verifier block.
// F_Q is the Mersenne prime 2^61-1, so 2^F_NBITS mod F_Q (F_Q_P2_MI) is 1.
package verifier_compute_beta_pkg;

  localparam int F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q = 61'h1FFF_FFFF_FFFF_FFFF;
  localparam logic [F_NBITS-1:0] F_Q_P2_MI = 61'd1;

  // Fixed latency of field_multiplier, in cycles from en to ready.
  localparam int MUL_LAT = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_WZ  = 3'd1,
    S_ADD_DBL = 3'd2,
    S_ADD_SUB = 3'd3,
    S_ADD_ONE = 3'd4,
    S_MUL_ACC = 3'd5
  } state_t;

  function automatic logic [F_NBITS-1:0] mod_add(input logic [F_NBITS-1:0] a,
                                                  input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  // Additive inverse; zero maps to zero so the result stays below F_Q.
  function automatic logic [F_NBITS-1:0] mod_neg(input logic [F_NBITS-1:0] b);
    return (b == '0) ? '0 : F_Q - b;
  endfunction

  // Two folds of hi*2^n == hi*F_Q_P2_MI, then one conditional subtract.
  function automatic logic [F_NBITS-1:0] mod_reduce(input logic [2*F_NBITS-1:0] x);
    logic [F_NBITS:0] f1;
    logic [F_NBITS:0] f2;
    f1 = {1'b0, x[F_NBITS-1:0]} + ({1'b0, x[2*F_NBITS-1:F_NBITS]} * {1'b0, F_Q_P2_MI});
    f2 = {1'b0, f1[F_NBITS-1:0]} + {{F_NBITS{1'b0}}, f1[F_NBITS]};
    if (f2 >= {1'b0, F_Q}) f2 = f2 - {1'b0, F_Q};
    return f2[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/verifier_compute_beta_mul.sv
// Pipelined modular multiplier: full product in stage 1, reduction in stage 2.
// A tag bit travels with each operation so the owner can tell results apart.
module field_multiplier
  import verifier_compute_beta_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  input  logic               tag_in,
  output logic [F_NBITS-1:0] result,
  output logic               ready,
  output logic               tag_out
);

  logic [2*F_NBITS-1:0] prod_r;
  logic                 v1;
  logic                 t1;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      prod_r  <= '0;
      v1      <= 1'b0;
      t1      <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
      tag_out <= 1'b0;
    end else begin
      v1      <= en;
      t1      <= tag_in & en;
      ready   <= v1;
      tag_out <= t1;
      if (en) prod_r <= {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
      if (v1) result <= mod_reduce(prod_r);
    end
  end

endmodule

// File: rtl/verifier_compute_beta.sv
// beta(w,z) = prod_i (w_i*z_i + (1-w_i)(1-z_i)) mod F_Q, using one adder and one
// multiplier that are lent out through the *_ext ports while the block is idle.
module verifier_compute_beta
  import verifier_compute_beta_pkg::*;
#(
  parameter int nCopyBits = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] w_vals [nCopyBits],
  input  logic [F_NBITS-1:0] z_vals [nCopyBits],
  input  logic               add_en_ext,
  input  logic [F_NBITS-1:0] add_in_ext [2],
  output logic [F_NBITS-1:0] add_out_ext,
  output logic               add_ready_ext,
  input  logic               mul_en_ext,
  input  logic [F_NBITS-1:0] mul_in_ext [2],
  output logic [F_NBITS-1:0] mul_out_ext,
  output logic               mul_ready_ext,
  output logic               ready,
  output logic [F_NBITS-1:0] beta_out,
  output logic [2:0]         fsm_state
);

  localparam int IW = (nCopyBits > 1) ? $clog2(nCopyBits) : 1;
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(nCopyBits - 1);
  localparam logic [CW-1:0] CNT_ISSUED = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_RESULT = CW'(MUL_LAT);

  state_t             state;
  logic [IW-1:0]      idx;
  logic [CW-1:0]      cnt;
  logic [F_NBITS-1:0] w_r [nCopyBits];
  logic [F_NBITS-1:0] z_r [nCopyBits];
  logic [F_NBITS-1:0] acc_r, s_r, d_r, e_r, term_r;
  logic               mul_go;
  logic               ext_add_acc, ext_mul_acc;
  logic               mul_en, mul_rdy, mul_tag;
  logic [F_NBITS-1:0] mul_a, mul_b, mul_res;

  // Handshakes: en is sampled only while idle and wins over ext requests; an ext
  // request is accepted in the cycle it is seen idle with en=0, answered by a
  // one-cycle *_ready_ext pulse, and silently dropped if it arrives while busy.
  always_comb begin
    ext_add_acc = (state == S_IDLE) && !en && add_en_ext;
    ext_mul_acc = (state == S_IDLE) && !en && mul_en_ext;
    mul_en      = mul_go | ext_mul_acc;
    mul_a       = mul_in_ext[0];
    mul_b       = mul_in_ext[1];
    if (state == S_MUL_WZ) begin
      mul_a = w_r[idx];
      mul_b = z_r[idx];
    end else if (state == S_MUL_ACC) begin
      mul_a = acc_r;
      mul_b = term_r;
    end
  end

  field_multiplier u_mul (
    .clk    (clk),
    .rstb   (rstb),
    .en     (mul_en),
    .a      (mul_a),
    .b      (mul_b),
    .tag_in (ext_mul_acc),
    .result (mul_res),
    .ready  (mul_rdy),
    .tag_out(mul_tag)
  );

  assign mul_out_ext   = mul_res;
  assign mul_ready_ext = mul_rdy & mul_tag;
  assign fsm_state     = state;

  // Multiply states last exactly MUL_LAT cycles; the following state reads the
  // product straight from the multiplier's output register.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state         <= S_IDLE;
      ready         <= 1'b1;
      beta_out      <= '0;
      acc_r         <= F_NBITS'(1);
      idx           <= '0;
      cnt           <= '0;
      mul_go        <= 1'b0;
      s_r           <= '0;
      d_r           <= '0;
      e_r           <= '0;
      term_r        <= '0;
      add_out_ext   <= '0;
      add_ready_ext <= 1'b0;
      for (int k = 0; k < nCopyBits; k++) begin
        w_r[k] <= '0;
        z_r[k] <= '0;
      end
    end else begin
      add_ready_ext <= 1'b0;
      mul_go        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            w_r    <= w_vals;
            z_r    <= z_vals;
            acc_r  <= F_NBITS'(1);
            idx    <= '0;
            cnt    <= '0;
            mul_go <= 1'b1;
            ready  <= 1'b0;
            state  <= S_MUL_WZ;
          end else if (ext_add_acc) begin
            add_out_ext   <= mod_add(add_in_ext[0], add_in_ext[1]);
            add_ready_ext <= 1'b1;
          end
        end
        S_MUL_WZ: begin
          if (cnt == '0) begin
            s_r <= mod_add(w_r[idx], z_r[idx]);
            // Previous bit's acc*term has just landed in the multiplier output.
            if (idx != '0) acc_r <= mul_res;
          end
          if (cnt == CNT_ISSUED) begin
            cnt   <= '0;
            state <= S_ADD_DBL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ADD_DBL: begin
          d_r   <= mod_add(mul_res, mul_res);
          state <= S_ADD_SUB;
        end
        S_ADD_SUB: begin
          e_r   <= mod_add(d_r, mod_neg(s_r));
          state <= S_ADD_ONE;
        end
        S_ADD_ONE: begin
          term_r <= mod_add(e_r, F_NBITS'(1));
          mul_go <= 1'b1;
          state  <= S_MUL_ACC;
        end
        S_MUL_ACC: begin
          if (idx != LAST_IDX && cnt == CNT_ISSUED) begin
            cnt    <= '0;
            idx    <= idx + 1'b1;
            mul_go <= 1'b1;
            state  <= S_MUL_WZ;
          end else if (cnt == CNT_RESULT) begin
            beta_out <= mul_res;
            ready    <= 1'b1;
            cnt      <= '0;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_verifier_compute_beta.sv
// Scoreboard bench for verifier_compute_beta: directed beta vectors, external
// adder/multiplier requests, back-to-back runs and a mid-run reset.
module tb_verifier_compute_beta;
  import verifier_compute_beta_pkg::*;

  localparam int N        = 4;
  localparam int MAX_WAIT = 200;

  typedef logic [F_NBITS-1:0] fe_t;

  logic clk = 1'b0;
  logic rstb = 1'b1;
  logic en = 1'b0;
  fe_t  w_vals [N];
  fe_t  z_vals [N];
  logic add_en_ext = 1'b0;
  fe_t  add_in_ext [2];
  fe_t  add_out_ext;
  logic add_ready_ext;
  logic mul_en_ext = 1'b0;
  fe_t  mul_in_ext [2];
  fe_t  mul_out_ext;
  logic mul_ready_ext;
  logic ready;
  fe_t  beta_out;
  logic [2:0] fsm_state;

  verifier_compute_beta #(.nCopyBits(N)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .en           (en),
    .w_vals       (w_vals),
    .z_vals       (z_vals),
    .add_en_ext   (add_en_ext),
    .add_in_ext   (add_in_ext),
    .add_out_ext  (add_out_ext),
    .add_ready_ext(add_ready_ext),
    .mul_en_ext   (mul_en_ext),
    .mul_in_ext   (mul_in_ext),
    .mul_out_ext  (mul_out_ext),
    .mul_ready_ext(mul_ready_ext),
    .ready        (ready),
    .beta_out     (beta_out),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  fe_t exp_q [$];
  fe_t add_q [$];
  fe_t mul_q [$];
  fe_t tw [N];
  fe_t tz [N];
  int  lat;
  int  mul_lat;

  task automatic check(input string name, input fe_t got, input fe_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: prod (w*z + (1-w)(1-z)) mod F_Q in wide integer arithmetic.
  function automatic fe_t model_beta();
    logic [127:0] q, acc, wz, a, b, t;
    q   = 128'(F_Q);
    acc = 128'd1;
    for (int i = 0; i < N; i++) begin
      wz  = (128'(tw[i]) * 128'(tz[i])) % q;
      a   = (q + 128'd1 - 128'(tw[i])) % q;
      b   = (q + 128'd1 - 128'(tz[i])) % q;
      t   = (wz + (a * b) % q) % q;
      acc = (acc * t) % q;
    end
    return fe_t'(acc);
  endfunction

  // ---------------- monitor ----------------
  logic ready_prev = 1'b1;
  always @(negedge clk) begin
    if (rstb) begin
      ready_prev = ready;
    end else begin
      if (ready && !ready_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beta_unexpected: got %0d expected no result", beta_out);
        end else check("beta_out", beta_out, exp_q.pop_front());
      end
      ready_prev = ready;
      if (add_ready_ext) begin
        if (add_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL add_unexpected: got pulse with %0d expected none", add_out_ext);
        end else check("add_out_ext", add_out_ext, add_q.pop_front());
      end
      if (mul_ready_ext) begin
        if (mul_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mul_unexpected: got pulse with %0d expected none", mul_out_ext);
        end else check("mul_out_ext", mul_out_ext, mul_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    if (ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: ready got %b after %0d cycles expected 1", name, ready, n);
    end
  endtask

  task automatic set_all(input fe_t w, input fe_t z);
    for (int i = 0; i < N; i++) begin
      tw[i] = w;
      tz[i] = z;
    end
  endtask

  // Called at a negedge with ready=1; inputs are scrambled after the start.
  task automatic start_run(input fe_t exp, input int hold, input bit push);
    for (int i = 0; i < N; i++) begin
      w_vals[i] = tw[i];
      z_vals[i] = tz[i];
    end
    en = 1'b1;
    if (push) exp_q.push_back(exp);
    repeat (hold) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_vals[i] = fe_t'(123 * (i + 1));
      z_vals[i] = fe_t'(77 * (i + 3));
    end
  endtask

  task automatic run_beta(input string name, input fe_t exp, input int hold);
    wait_ready({name, "_pre"});
    start_run(exp, hold, 1'b1);
    wait_ready(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      w_vals[i] = '0;
      z_vals[i] = '0;
    end
    add_in_ext[0] = '0; add_in_ext[1] = '0;
    mul_in_ext[0] = '0; mul_in_ext[1] = '0;
    repeat (3) @(negedge clk);
    #2 rstb = 1'b0;
    @(negedge clk);

    check("rst_ready", fe_t'(ready), fe_t'(1));
    check("rst_beta_out", beta_out, '0);
    check("rst_add_out_ext", add_out_ext, '0);
    check("rst_mul_out_ext", mul_out_ext, '0);
    check("rst_add_ready_ext", fe_t'(add_ready_ext), '0);
    check("rst_mul_ready_ext", fe_t'(mul_ready_ext), '0);
    check("rst_fsm_state", fe_t'(fsm_state), fe_t'(S_IDLE));

    // External add: (F_Q-1)+2 wraps to 1, single pulse one cycle later.
    add_in_ext[0] = F_Q - 1; add_in_ext[1] = fe_t'(2);
    add_en_ext = 1'b1;
    add_q.push_back(fe_t'(1));
    @(negedge clk);
    add_en_ext = 1'b0;
    check("add_ready_latency", fe_t'(add_ready_ext), fe_t'(1));
    @(negedge clk);
    check("add_ready_single", fe_t'(add_ready_ext), '0);
    check("ready_during_ext", fe_t'(ready), fe_t'(1));

    // External multiply: (-1)*(-1) = 1, and measure its latency.
    mul_in_ext[0] = F_Q - 1; mul_in_ext[1] = F_Q - 1;
    mul_en_ext = 1'b1;
    mul_q.push_back(fe_t'(1));
    @(negedge clk);
    mul_en_ext = 1'b0;
    mul_lat = 1;
    while (!mul_ready_ext && mul_lat < MAX_WAIT) begin
      @(negedge clk);
      mul_lat++;
    end
    if (!mul_ready_ext) begin
      checks++; errors++;
      $display("FAIL mul_ext_timeout: got no pulse after %0d cycles", mul_lat);
    end
    @(negedge clk);
    check("mul_ready_single", fe_t'(mul_ready_ext), '0);

    // Both units requested together.
    add_in_ext[0] = fe_t'(5); add_in_ext[1] = fe_t'(7);
    mul_in_ext[0] = fe_t'(6); mul_in_ext[1] = fe_t'(7);
    add_en_ext = 1'b1; mul_en_ext = 1'b1;
    add_q.push_back(fe_t'(12));
    mul_q.push_back(fe_t'(42));
    @(negedge clk);
    add_en_ext = 1'b0; mul_en_ext = 1'b0;
    repeat (mul_lat + 2) @(negedge clk);

    // All zero, with ext requests colliding with en (en wins, ext dropped).
    set_all('0, '0);
    add_en_ext = 1'b1; mul_en_ext = 1'b1;
    start_run(fe_t'(1), 1, 1'b1);
    add_en_ext = 1'b0; mul_en_ext = 1'b0;
    wait_ready("beta_zeros");

    set_all(fe_t'(1), fe_t'(1));
    run_beta("beta_ones_en_held", fe_t'(1), 3);

    set_all('0, '0);
    tw[0] = fe_t'(1);
    run_beta("beta_one_mismatch", '0, 1);

    set_all(fe_t'(2), fe_t'(3));
    wait_ready("beta_2_3_pre");
    start_run(fe_t'(4096), 1, 1'b1);
    wait_ready("beta_2_3");
    checks++;
    if (lat < N * (2 * mul_lat + 3) || lat > N * (2 * mul_lat + 3) + 2) begin
      errors++;
      $display("FAIL run_latency: got %0d cycles expected %0d..%0d", lat,
               N * (2 * mul_lat + 3), N * (2 * mul_lat + 3) + 2);
    end

    set_all(F_Q - 1, F_Q - 1);
    run_beta("beta_minus1", fe_t'(625), 1);

    set_all(F_Q - 1, '0);
    run_beta("beta_minus1_zero", fe_t'(16), 1);

    // Mixed bits; ext requests while busy must be dropped.
    tw[0] = '0;        tz[0] = '0;
    tw[1] = fe_t'(1);  tz[1] = fe_t'(1);
    tw[2] = fe_t'(2);  tz[2] = fe_t'(3);
    tw[3] = fe_t'(5);  tz[3] = fe_t'(7);
    wait_ready("beta_mixed_pre");
    start_run(fe_t'(472), 1, 1'b1);
    repeat (4) @(negedge clk);
    add_en_ext = 1'b1; mul_en_ext = 1'b1;
    repeat (2) @(negedge clk);
    add_en_ext = 1'b0; mul_en_ext = 1'b0;
    wait_ready("beta_mixed");

    // Ext op after a run leaves beta_out and ready alone.
    add_in_ext[0] = fe_t'(10); add_in_ext[1] = fe_t'(20);
    add_en_ext = 1'b1;
    add_q.push_back(fe_t'(30));
    @(negedge clk);
    add_en_ext = 1'b0;
    @(negedge clk);
    check("beta_hold_after_ext", beta_out, fe_t'(472));
    check("ready_after_ext", fe_t'(ready), fe_t'(1));

    // Back-to-back full-width vectors, en raised right after each ready rise.
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) begin
        tw[i] = fe_t'({$urandom(), $urandom()} % 64'(F_Q));
        tz[i] = fe_t'({$urandom(), $urandom()} % 64'(F_Q));
      end
      wait_ready("beta_b2b_pre");
      start_run(model_beta(), 1, 1'b1);
    end
    wait_ready("beta_b2b_last");

    // Reset in the middle of a run: no result, outputs back to reset values.
    set_all(fe_t'(2), fe_t'(3));
    start_run('0, 1, 1'b0);
    repeat (10) @(negedge clk);
    #2 rstb = 1'b1;
    #1;
    check("midrun_rst_ready", fe_t'(ready), fe_t'(1));
    check("midrun_rst_beta", beta_out, '0);
    @(negedge clk);
    #2 rstb = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_fsm_state", fe_t'(fsm_state), fe_t'(S_IDLE));
    check("post_rst_beta", beta_out, '0);

    set_all(F_Q - 1, F_Q - 1);
    run_beta("beta_after_rst", fe_t'(625), 1);

    repeat (mul_lat + 5) @(negedge clk);
    check("beta_queue_empty", fe_t'(exp_q.size()), '0);
    check("add_queue_empty", fe_t'(add_q.size()), '0);
    check("mul_queue_empty", fe_t'(mul_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got no end by 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/verifier_compute_beta.md
# verifier_compute_beta

Computes the sum-check verifier's copy-wiring term beta(w,z) = ∏ᵢ (wᵢ·zᵢ + (1−wᵢ)(1−zᵢ)) mod F_Q over nCopyBits field-element pairs. It sits in the verifier datapath, using one shared modular adder and one modular multiplier. While idle, those arithmetic units are lent to neighbouring blocks through the *_ext ports.

## Interface
- nCopyBits, default 4: number of (w,z) pairs; must be ≥1.
- clk  in  1  clock, rising edge.
- rstb  in  1  reset, asynchronous, active-high.
- en  in  1  start request; sampled only when ready=1.
- w_vals  in  nCopyBits×F_NBITS  unpacked array of field elements (< F_Q).
- z_vals  in  nCopyBits×F_NBITS  unpacked array of field elements (< F_Q).
- add_en_ext  in  1  external add request (idle only).
- add_in_ext  in  2×F_NBITS  external addends.
- add_out_ext  out  F_NBITS  (add_in_ext[0]+add_in_ext[1]) mod F_Q.
- add_ready_ext  out  1  one-cycle pulse when add_out_ext is valid.
- mul_en_ext  in  1  external multiply request (idle only).
- mul_in_ext  in  2×F_NBITS  external operands.
- mul_out_ext  out  F_NBITS  product mod F_Q.
- mul_ready_ext  out  1  one-cycle pulse when mul_out_ext is valid.
- ready  out  1  high when idle; beta_out is valid whenever ready=1 after a completed run.
- beta_out  out  F_NBITS  result, held until the next run completes.

## Operation
- Per bit i, term = 1 + 2·wᵢzᵢ − wᵢ − zᵢ (mod F_Q), which equals wᵢzᵢ + (1−wᵢ)(1−zᵢ).
- acc starts at 1. For each bit, acc ← acc·term. beta_out ← acc after the last bit.
- FSM states: IDLE → MUL_WZ → ADD_DBL → ADD_SUB → ADD_ONE → MUL_ACC.
  - MUL_WZ: p = w·z; the adder computes s = w+z in parallel.
  - ADD_DBL: d = p+p.
  - ADD_SUB: e = d−s.
  - ADD_ONE: term = e+1.
  - MUL_ACC: acc ← acc·term, then i++.
  - MUL_ACC returns to MUL_WZ if i < nCopyBits, otherwise goes to IDLE and loads beta_out.
- w_vals and z_vals are captured into internal registers on start. Input changes during a run have no effect.
- All arithmetic is fully reduced mod F_Q. Subtraction is done as a + (F_Q − b).
- External requests are accepted only in IDLE with en=0; en has priority.
  - If add_en_ext and mul_en_ext arrive together, both are served, one per unit.
  - An ext request arriving while busy is dropped, and no ready pulse is generated for it.
  - Ext ops never disturb beta_out or ready.

## Timing
- Reset values: ready=1, beta_out=0, add_out_ext=0, mul_out_ext=0, add_ready_ext=0, mul_ready_ext=0. FSM goes to IDLE and acc=1.
- Start: en=1 at a rising edge with ready=1 → ready=0 from the next cycle.
- en held high for several cycles starts exactly one run.
- Completion:
  - On the cycle the final multiply finishes, beta_out is registered and ready returns to 1 on the same edge.
  - The result must not be ready=1 with a stale beta_out.
- en asserted on the cycle after ready rises starts the next run back-to-back.
- Adder latency is 1 cycle (registered). Multiplier latency is a fixed L cycles (implementation-defined, ≥1).
- Run latency = nCopyBits·(2L+3) cycles plus at most 2 cycles of overhead.
- External op latency:
  - add_ready_ext pulses 1 cycle after acceptance.
  - mul_ready_ext pulses L cycles after acceptance.
  - ready stays 1 throughout.
- Reset asserted mid-run aborts immediately; no partial result is written.

## Structure
- F_NBITS, F_Q, and F_Q_P2_MI (2^F_NBITS mod F_Q helper) come from the shared field package/header; nothing is redefined locally.
- The modular multiplier is the natural sub-module, field_multiplier (en/ready handshake, L-cycle latency). It is shared between the FSM and the ext port.
- The modular add/sub is inline logic.

## Test plan
- w=z=all 0 (nCopyBits=4) → beta_out=1.
- w=z=all 1 → beta_out=1.
- One bit with w=1, z=0, the rest 0 → beta_out=0.
- Every bit with w=2, z=3 (term=8) → beta_out=4096 mod F_Q.
- 8 random full-width vectors, back-to-back:
  - en pulses on each ready rising edge.
  - beta_out matches the software model ∏(wz+(1−w)(1−z)) mod F_Q each time.
- Reset mid-run → ready=1 and beta_out=0.
- While idle, add_en_ext with inputs F_Q−1 and 2 → add_out_ext=1 with a single pulse.
